spram_arbiter: RTL and testbench

//   Shares one 32-bit x 32K-word single-port RAM between two requesters (m0: CPU, m1: DMA/video).

---
 rtl/spram_arbiter_if.sv | 47 ++++
 rtl/spram_arbiter.sv | 85 ++++++++
 tb/tb_spram_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/spram_arbiter_if.sv
// Requester-side and RAM-side signal bundle for the two-port single-port-RAM arbiter.
// The arbiter uses the slave modport. The requesters and the RAM use the master modport.
interface spram_arbiter_if;
  // Requester 0 (CPU)
  logic        m0_req_i;
  logic        m0_we_i;
  logic [3:0]  m0_wmask_i;
  logic [14:0] m0_addr_i;
  logic [31:0] m0_wdata_i;
  logic        m0_gnt_o;
  logic        m0_rvalid_o;
  logic [31:0] m0_rdata_o;
  // Requester 1 (DMA/video)
  logic        m1_req_i;
  logic        m1_we_i;
  logic [3:0]  m1_wmask_i;
  logic [14:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic        m1_gnt_o;
  logic        m1_rvalid_o;
  logic [31:0] m1_rdata_o;
  // RAM side
  logic        ram_sel_o;
  logic        ram_wr_en_o;
  logic [3:0]  ram_wr_mask_o;
  logic [14:0] ram_address_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_wmask_i, m0_addr_i, m0_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_req_i, m1_we_i, m1_wmask_i, m1_addr_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output ram_sel_o, ram_wr_en_o, ram_wr_mask_o, ram_address_o, ram_data_o,
    input  ram_data_i
  );

  modport master (
    output m0_req_i, m0_we_i, m0_wmask_i, m0_addr_i, m0_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_req_i, m1_we_i, m1_wmask_i, m1_addr_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  ram_sel_o, ram_wr_en_o, ram_wr_mask_o, ram_address_o, ram_data_o,
    output ram_data_i
  );
endinterface

// File: rtl/spram_arbiter.sv
// Two-requester arbiter in front of a 32-bit x 32K-word single-port RAM.
// It grants at most one access per cycle. A granted read returns its data to the
// owning port one cycle later, taken from the RAM's registered read data.
module spram_arbiter #(
  parameter int unsigned RR_EN    = 1,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic           clk,
  input  logic           reset_n_i,
  spram_arbiter_if.slave bus
);

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  logic       last_gnt_q, last_gnt_d;   // 1 = m1 won the last granted access
  logic       rd_pend_q,  rd_pend_d;
  logic       rd_owner_q, rd_owner_d;   // 1 = pending read belongs to m1
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic        tie_m1;
  logic        win_m1;
  logic        gnt0, gnt1, any_gnt;
  logic        win_we;
  logic [3:0]  win_mask;
  logic [14:0] win_addr;
  logic [31:0] win_wdata;

  // Choose the winner among the active requests and steer its command to the RAM.
  always_comb begin
    if (RR_EN != 0) tie_m1 = ~last_gnt_q;
    else            tie_m1 = (wait_cnt_q == WAIT_LIM);
    win_m1  = bus.m1_req_i & (~bus.m0_req_i | tie_m1);
    gnt0    = reset_n_i & bus.m0_req_i & ~win_m1;
    gnt1    = reset_n_i & win_m1;
    any_gnt = gnt0 | gnt1;

    win_we    = win_m1 ? bus.m1_we_i    : bus.m0_we_i;
    win_mask  = win_m1 ? bus.m1_wmask_i : bus.m0_wmask_i;
    win_addr  = win_m1 ? bus.m1_addr_i  : bus.m0_addr_i;
    win_wdata = win_m1 ? bus.m1_wdata_i : bus.m0_wdata_i;

    bus.m0_gnt_o      = gnt0;
    bus.m1_gnt_o      = gnt1;
    bus.ram_sel_o     = any_gnt;
    bus.ram_wr_en_o   = any_gnt & win_we;
    bus.ram_wr_mask_o = any_gnt ? win_mask  : '0;
    bus.ram_address_o = any_gnt ? win_addr  : '0;
    bus.ram_data_o    = any_gnt ? win_wdata : '0;
  end

  // Compute the next arbitration state and the next read-tag state.
  always_comb begin
    last_gnt_d = any_gnt ? win_m1 : last_gnt_q;
    rd_pend_d  = any_gnt & ~win_we;
    rd_owner_d = any_gnt ? win_m1 : rd_owner_q;
    wait_cnt_d = '0;
    if (RR_EN == 0 && bus.m1_req_i && !gnt1) begin
      wait_cnt_d = (wait_cnt_q == WAIT_LIM) ? WAIT_LIM : wait_cnt_q + 8'd1;
    end
  end

  // Register the state. Reset leaves m0 as the winner of the first tie.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_gnt_q <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Return read data: both ports see the RAM data, and only the owner gets rvalid.
  always_comb begin
    bus.m0_rvalid_o = rd_pend_q & ~rd_owner_q;
    bus.m1_rvalid_o = rd_pend_q &  rd_owner_q;
    bus.m0_rdata_o  = reset_n_i ? bus.ram_data_i : '0;
    bus.m1_rdata_o  = reset_n_i ? bus.ram_data_i : '0;
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter. It uses a round-robin instance and a
// fixed-priority instance with MAX_WAIT=4, and each instance has its own RAM model.
module tb_spram_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [31:0] mem_a [0:32767];
  logic [31:0] mem_b [0:32767];
  logic [31:0] wr_a, wr_b;

  spram_arbiter_if ifa ();
  spram_arbiter_if ifb ();

  spram_arbiter #(.RR_EN(1), .MAX_WAIT(8)) dut_a (.clk(clk), .reset_n_i(rst_n), .bus(ifa));
  spram_arbiter #(.RR_EN(0), .MAX_WAIT(4)) dut_b (.clk(clk), .reset_n_i(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model A: masked writes, and registered read data one cycle after the access.
  always @(posedge clk) begin
    if (ifa.ram_sel_o) begin
      if (ifa.ram_wr_en_o) begin
        wr_a = mem_a[ifa.ram_address_o];
        for (int k = 0; k < 4; k++)
          if (ifa.ram_wr_mask_o[k]) wr_a[8*k +: 8] = ifa.ram_data_o[8*k +: 8];
        mem_a[ifa.ram_address_o] = wr_a;
      end else begin
        ifa.ram_data_i <= mem_a[ifa.ram_address_o];
      end
    end
  end

  // RAM model B: the same behaviour for the fixed-priority instance.
  always @(posedge clk) begin
    if (ifb.ram_sel_o) begin
      if (ifb.ram_wr_en_o) begin
        wr_b = mem_b[ifb.ram_address_o];
        for (int k = 0; k < 4; k++)
          if (ifb.ram_wr_mask_o[k]) wr_b[8*k +: 8] = ifb.ram_data_o[8*k +: 8];
        mem_b[ifb.ram_address_o] = wr_b;
      end else begin
        ifb.ram_data_i <= mem_b[ifb.ram_address_o];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      mem_a[i] = 32'hC0DE0000 | 32'(i);
      mem_b[i] = 32'hC0DE0000 | 32'(i);
    end
    mem_a[16]      = 32'h12345678;
    mem_a[16'h4000] = 32'h00000000;
    ifa.ram_data_i = '0;
    ifb.ram_data_i = '0;
    ifa.m0_req_i = 1'b0; ifa.m0_we_i = 1'b0; ifa.m0_wmask_i = '0; ifa.m0_addr_i = '0; ifa.m0_wdata_i = '0;
    ifa.m1_req_i = 1'b0; ifa.m1_we_i = 1'b0; ifa.m1_wmask_i = '0; ifa.m1_addr_i = '0; ifa.m1_wdata_i = '0;
    ifb.m0_req_i = 1'b0; ifb.m0_we_i = 1'b0; ifb.m0_wmask_i = '0; ifb.m0_addr_i = '0; ifb.m0_wdata_i = '0;
    ifb.m1_req_i = 1'b0; ifb.m1_we_i = 1'b0; ifb.m1_wmask_i = '0; ifb.m1_addr_i = '0; ifb.m1_wdata_i = '0;

    // Reset state. A request held during reset must not be granted.
    ifa.m0_req_i = 1'b1;
    #2;
    chk("rst_gnt0",    32'(ifa.m0_gnt_o),    32'd0);
    chk("rst_sel",     32'(ifa.ram_sel_o),   32'd0);
    chk("rst_wren",    32'(ifa.ram_wr_en_o), 32'd0);
    chk("rst_rvalid0", 32'(ifa.m0_rvalid_o), 32'd0);
    chk("rst_rvalid1", 32'(ifa.m1_rvalid_o), 32'd0);
    ifa.m0_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Test 1: single read by m0.
    ifa.m0_req_i = 1'b1; ifa.m0_we_i = 1'b0; ifa.m0_addr_i = 15'h0010;
    #1;
    chk("t1_gnt0", 32'(ifa.m0_gnt_o),     32'd1);
    chk("t1_gnt1", 32'(ifa.m1_gnt_o),     32'd0);
    chk("t1_sel",  32'(ifa.ram_sel_o),    32'd1);
    chk("t1_wren", 32'(ifa.ram_wr_en_o),  32'd0);
    chk("t1_addr", 32'(ifa.ram_address_o), 32'h0010);
    tick();
    ifa.m0_req_i = 1'b0;
    #1;
    chk("t1_rvalid0", 32'(ifa.m0_rvalid_o), 32'd1);
    chk("t1_rdata0",  ifa.m0_rdata_o,       32'h12345678);
    chk("t1_rvalid1", 32'(ifa.m1_rvalid_o), 32'd0);
    chk("t1_sel_idle", 32'(ifa.ram_sel_o),  32'd0);
    tick();
    chk("t1_rvalid0_end", 32'(ifa.m0_rvalid_o), 32'd0);

    // Test 2: starting from reset, round-robin between two continuous readers.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    ifa.m0_req_i = 1'b1; ifa.m0_we_i = 1'b0; ifa.m0_addr_i = 15'h0020;
    ifa.m1_req_i = 1'b1; ifa.m1_we_i = 1'b0; ifa.m1_addr_i = 15'h0030;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t2_gnt0", 32'(ifa.m0_gnt_o), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_gnt1", 32'(ifa.m1_gnt_o), (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i > 0) begin
        chk("t2_rvalid0", 32'(ifa.m0_rvalid_o), (i % 2 == 1) ? 32'd1 : 32'd0);
        chk("t2_rvalid1", 32'(ifa.m1_rvalid_o), (i % 2 == 0) ? 32'd1 : 32'd0);
        chk("t2_rdata",   ifa.m0_rdata_o, (i % 2 == 1) ? 32'hC0DE0020 : 32'hC0DE0030);
      end
      tick();
    end
    ifa.m0_req_i = 1'b0;
    ifa.m1_req_i = 1'b0;
    #1;
    chk("t2_last_rvalid1", 32'(ifa.m1_rvalid_o), 32'd1);
    chk("t2_last_rdata1",  ifa.m1_rdata_o,       32'hC0DE0030);
    tick();

    // Test 3: masked write by m1, then a read of the same word.
    ifa.m1_req_i = 1'b1; ifa.m1_we_i = 1'b1; ifa.m1_addr_i = 15'h4000;
    ifa.m1_wmask_i = 4'b0100; ifa.m1_wdata_i = 32'hAABBCCDD;
    #1;
    chk("t3_gnt1",  32'(ifa.m1_gnt_o),      32'd1);
    chk("t3_wren",  32'(ifa.ram_wr_en_o),   32'd1);
    chk("t3_mask",  32'(ifa.ram_wr_mask_o), 32'b0100);
    chk("t3_wdata", ifa.ram_data_o,         32'hAABBCCDD);
    tick();
    ifa.m1_we_i = 1'b0;
    #1;
    chk("t3_no_rvalid1", 32'(ifa.m1_rvalid_o), 32'd0);
    chk("t3_b2b_gnt1",   32'(ifa.m1_gnt_o),    32'd1);
    tick();
    ifa.m1_req_i = 1'b0;
    #1;
    chk("t3_rvalid1", 32'(ifa.m1_rvalid_o), 32'd1);
    chk("t3_rdata1",  ifa.m1_rdata_o,       32'h00BB0000);
    tick();

    // Test 5: reset arrives in the cycle after an m0 read grant.
    ifa.m0_req_i = 1'b1; ifa.m0_we_i = 1'b0; ifa.m0_addr_i = 15'h0010;
    #1;
    chk("t5_gnt0", 32'(ifa.m0_gnt_o), 32'd1);
    tick();
    ifa.m0_req_i = 1'b0;
    #1;
    chk("t5_pre_rvalid0", 32'(ifa.m0_rvalid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rvalid0", 32'(ifa.m0_rvalid_o), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("t5_post_rvalid0", 32'(ifa.m0_rvalid_o), 32'd0);
    ifa.m0_req_i = 1'b1; ifa.m1_req_i = 1'b1;
    ifa.m0_addr_i = 15'h0020; ifa.m1_addr_i = 15'h0030;
    #1;
    chk("t5_tie_gnt0", 32'(ifa.m0_gnt_o), 32'd1);
    chk("t5_tie_gnt1", 32'(ifa.m1_gnt_o), 32'd0);
    tick();
    ifa.m0_req_i = 1'b0; ifa.m1_req_i = 1'b0;
    tick();

    // Test 6: ten idle cycles.
    for (int i = 0; i < 10; i++) begin
      chk("t6_sel",     32'(ifa.ram_sel_o),   32'd0);
      chk("t6_wren",    32'(ifa.ram_wr_en_o), 32'd0);
      chk("t6_gnt",     32'({ifa.m1_gnt_o, ifa.m0_gnt_o}), 32'd0);
      chk("t6_rvalid",  32'({ifa.m1_rvalid_o, ifa.m0_rvalid_o}), 32'd0);
      tick();
    end

    // Test 4: fixed priority with MAX_WAIT=4 and both ports requesting continuously.
    ifb.m0_req_i = 1'b1; ifb.m0_we_i = 1'b0; ifb.m0_addr_i = 15'h0001;
    ifb.m1_req_i = 1'b1; ifb.m1_we_i = 1'b0; ifb.m1_addr_i = 15'h0002;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("t4_gnt1", 32'(ifb.m1_gnt_o), (c == 4 || c == 9) ? 32'd1 : 32'd0);
      chk("t4_gnt0", 32'(ifb.m0_gnt_o), (c == 4 || c == 9) ? 32'd0 : 32'd1);
      if (c == 5) begin
        chk("t4_rvalid1", 32'(ifb.m1_rvalid_o), 32'd1);
        chk("t4_rdata1",  ifb.m1_rdata_o,       32'hC0DE0002);
      end
      tick();
    end
    ifb.m0_req_i = 1'b0; ifb.m1_req_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
